// File: rtl/spi_sensor_slave.sv
// SPI responder emulating a 16-bit sensor: one MSB-first frame per ss_n low window, fed by a
// one-entry valid/ready holding register. Optional build macro: SPI_SLV_PARITY_EN (bit 0 = parity).
module spi_sensor_slave #(
  parameter int FRAME_W  = 16,
  parameter int DATA_W   = 12,
  parameter int DATA_LSB = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              ss_n,
  input  logic              sclk,
  output logic              miso,
  output logic              miso_oe,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun,
  output logic              state_dbg
);

  localparam int CNT_W = $clog2(FRAME_W + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Sample handshake: sample_in is taken on a clk edge where sample_valid && sample_ready.
  // sample_ready is simply "holding register empty" and does not depend on sample_valid.

  state_t              state_q;
  logic [DATA_W-1:0]   hold_q, last_q;
  logic                hold_full_q;
  logic [FRAME_W-1:0]  shift_q;
  logic [CNT_W-1:0]    fall_cnt_q;
  logic                miso_q, miso_oe_q, busy_q, frame_done_q, underrun_q;
  logic                ss_meta_q, ss_sync_q, ss_prev_q;
  logic                sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic                ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [DATA_W-1:0]   start_sample_d;
  logic [FRAME_W-1:0]  start_frame_d;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] s);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[DATA_LSB +: DATA_W] = s;
`ifdef SPI_SLV_PARITY_EN
    f[0] = ^s;
`endif
    return f;
  endfunction

  // ss_n syncs reset low so a select already active at reset release never looks like a fall.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      {ss_meta_q, ss_sync_q, ss_prev_q}       <= 3'b000;
      {sclk_meta_q, sclk_sync_q, sclk_prev_q} <= 3'b111;
    end else begin
      {ss_meta_q, ss_sync_q, ss_prev_q}       <= {ss_n, ss_meta_q, ss_sync_q};
      {sclk_meta_q, sclk_sync_q, sclk_prev_q} <= {sclk, sclk_meta_q, sclk_sync_q};
    end
  end

  assign ss_fall   =  ss_prev_q   & ~ss_sync_q;
  assign ss_rise   = ~ss_prev_q   &  ss_sync_q;
  assign sclk_rise = ~sclk_prev_q &  sclk_sync_q;
  assign sclk_fall =  sclk_prev_q & ~sclk_sync_q;

  always_comb begin
    start_sample_d = last_q;
    if (hold_full_q)       start_sample_d = hold_q;
    else if (sample_valid) start_sample_d = sample_in;
    start_frame_d = build_frame(start_sample_d);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      last_q       <= '0;
      shift_q      <= '0;
      fall_cnt_q   <= '0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      if (sample_valid && !hold_full_q) begin
        hold_q      <= sample_in;
        hold_full_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q    <= SHIFT;
            busy_q     <= 1'b1;
            miso_oe_q  <= 1'b1;
            fall_cnt_q <= '0;
            shift_q    <= start_frame_d;
            miso_q     <= start_frame_d[FRAME_W-1];
            // Bypass also lands here: the fresh sample goes straight out, hold stays empty.
            if (hold_full_q || sample_valid) begin
              hold_full_q <= 1'b0;
              last_q      <= start_sample_d;
            end else begin
              underrun_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            miso_q       <= 1'b0;
            frame_done_q <= (fall_cnt_q >= CNT_W'(FRAME_W));
          end else begin
            if (sclk_rise) begin
              shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
              miso_q  <= shift_q[FRAME_W-2];
            end
            if (sclk_fall && (fall_cnt_q < CNT_W'(FRAME_W)))
              fall_cnt_q <= fall_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_ready = ~hold_full_q;
  assign miso         = miso_q;
  assign miso_oe      = miso_oe_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign underrun     = underrun_q;
  assign state_dbg    = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_sensor_slave.sv
// Directed bench for spi_sensor_slave: acts as the SPI master (SCLK = clk/8, idle high) and
// compares captured frames and status pulses against hand-computed values.
module tb_spi_sensor_slave;

`ifdef SPI_SLV_PARITY_EN
  localparam logic [15:0] EXP_ABC = 16'h55E1;
  localparam logic [15:0] EXP_001 = 16'h0009;
`else
  localparam logic [15:0] EXP_ABC = 16'h55E0;
  localparam logic [15:0] EXP_001 = 16'h0008;
`endif
  localparam logic [15:0] EXP_FFF = 16'h7FF8;
  localparam logic [15:0] EXP_003 = 16'h0018;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        ss_n = 1'b1;
  logic        sclk = 1'b1;
  logic        miso, miso_oe, busy, frame_done, underrun, state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;
  int ur_cnt  = 0;
  int fd0, ur0;
  logic        st_ready, st_oe, st_busy, tail_miso;
  logic [15:0] stream;

  spi_sensor_slave dut (
    .clk(clk), .rstn(rstn), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .ss_n(ss_n), .sclk(sclk), .miso(miso), .miso_oe(miso_oe),
    .busy(busy), .frame_done(frame_done), .underrun(underrun), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && frame_done) fd_cnt <= fd_cnt + 1;
    if (rstn && underrun)   ur_cnt <= ur_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [11:0] v);
    int n;
    n = 0;
    while (!sample_ready && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) check_eq("push_timeout", 32'd1, 32'd0);
    sample_in    = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  // Master frame: optional bypass puts a sample on the bus exactly at the detection edge.
  task automatic run_frame(input int nsclk, input logic bypass, input logic [11:0] bval);
    ss_n = 1'b0;
    tick();
    tick();
    if (bypass) begin
      sample_in    = bval;
      sample_valid = 1'b1;
    end
    tick();
    sample_valid = 1'b0;
    tick();
    st_ready = sample_ready;
    st_oe    = miso_oe;
    st_busy  = busy;
    stream   = '0;
    for (int i = 0; i < nsclk; i++) begin
      sclk = 1'b0;
      if (i < 16) stream = {stream[14:0], miso};
      repeat (4) tick();
      sclk = 1'b1;
      repeat (4) tick();
    end
    tail_miso = miso;
    ss_n = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst_ready", sample_ready, 1);
    check_eq("rst_miso", miso, 0);
    check_eq("rst_oe", miso_oe, 0);
    check_eq("rst_busy", busy, 0);
    rstn = 1'b1;
    repeat (3) tick();
    check_eq("rst_state", state_dbg, 0);

    // T1: normal frame
    push(12'hABC);
    check_eq("t1_ready_full", sample_ready, 0);
    fd0 = fd_cnt; ur0 = ur_cnt;
    run_frame(16, 1'b0, '0);
    check_eq("t1_ready_start", st_ready, 1);
    check_eq("t1_oe", st_oe, 1);
    check_eq("t1_busy", st_busy, 1);
    check_eq("t1_stream", stream, EXP_ABC);
    check_eq("t1_tail", tail_miso, 0);
    check_eq("t1_done", fd_cnt - fd0, 1);
    check_eq("t1_underrun", ur_cnt - ur0, 0);
    check_eq("t1_oe_end", miso_oe, 0);
    check_eq("t1_busy_end", busy, 0);
    check_eq("t1_miso_end", miso, 0);

    // T2: underrun resends last sample; extra SCLKs keep miso low
    fd0 = fd_cnt; ur0 = ur_cnt;
    run_frame(20, 1'b0, '0);
    check_eq("t2_underrun", ur_cnt - ur0, 1);
    check_eq("t2_stream", stream, EXP_ABC);
    check_eq("t2_tail", tail_miso, 0);
    check_eq("t2_done", fd_cnt - fd0, 1);

    // T3: bypass
    fd0 = fd_cnt; ur0 = ur_cnt;
    run_frame(16, 1'b1, 12'h001);
    check_eq("t3_stream", stream, EXP_001);
    check_eq("t3_underrun", ur_cnt - ur0, 0);
    check_eq("t3_ready", sample_ready, 1);
    check_eq("t3_done", fd_cnt - fd0, 1);

    // T4: aborted frame, sample stays consumed
    push(12'hFFF);
    fd0 = fd_cnt; ur0 = ur_cnt;
    run_frame(7, 1'b0, '0);
    check_eq("t4_abort_done", fd_cnt - fd0, 0);
    check_eq("t4_ready", sample_ready, 1);
    fd0 = fd_cnt; ur0 = ur_cnt;
    run_frame(16, 1'b0, '0);
    check_eq("t4_underrun", ur_cnt - ur0, 1);
    check_eq("t4_stream", stream, EXP_FFF);

    // T5: reset mid-frame with ss_n held low
    ss_n = 1'b0;
    repeat (4) tick();
    check_eq("t5_oe_pre", miso_oe, 1);
    push(12'h5A5);
    check_eq("t5_ready_pre", sample_ready, 0);
    sclk = 1'b0; repeat (4) tick();
    sclk = 1'b1; repeat (4) tick();
    rstn = 1'b0;
    repeat (2) tick();
    check_eq("t5_miso", miso, 0);
    check_eq("t5_oe", miso_oe, 0);
    check_eq("t5_ready", sample_ready, 1);
    check_eq("t5_busy", busy, 0);
    rstn = 1'b1;
    ur0 = ur_cnt;
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b0; repeat (4) tick();
      sclk = 1'b1; repeat (4) tick();
    end
    check_eq("t5_oe_held", miso_oe, 0);
    check_eq("t5_busy_held", busy, 0);
    check_eq("t5_no_start", ur_cnt - ur0, 0);
    ss_n = 1'b1;
    repeat (4) tick();
    ur0 = ur_cnt;
    run_frame(16, 1'b0, '0);
    check_eq("t5_post_underrun", ur_cnt - ur0, 1);
    check_eq("t5_post_stream", stream, 16'h0000);

    // T6: another pushed value
    push(12'h003);
    run_frame(16, 1'b0, '0);
    check_eq("t6_stream", stream, EXP_003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
